cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters SHALL be as follows.
- s_line, default 256, cache line width in bits.
- s_burst, default 64, physical memory beat width in bits.
- num_beats, default s_line/s_burst (4), beats per line.
REQ-002 Ports SHALL be as follows.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- line_i  in  s_line  write-back line from the cache datapath.
- line_o  out  s_line  assembled fill line to the cache datapath.
- address_i  in  32  line address from cache control (pmem_address).
- read_i  in  1  line read request from cache control (pmem_read).
- write_i  in  1  line write request from cache control (pmem_write).
- resp_o  out  1  line transfer complete, to cache control (pmem_resp).
- burst_i  in  s_burst  read beat from physical memory.
- burst_o  out  s_burst  write beat to physical memory.
- address_o  out  32  burst base address to physical memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  beat valid/accepted strobe from physical memory.

Function
REQ-003 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-004 In IDLE with read_i=1, the block SHALL latch address_i and enter READ on the next edge.
REQ-005 In IDLE with write_i=1 and read_i=0, the block SHALL latch address_i and line_i and enter WRITE on the next edge.
REQ-006 If read_i and write_i are both 1 in IDLE, read SHALL take precedence and write_i SHALL be ignored.
REQ-007 address_o SHALL equal the latched address with bits [4:0] forced to 0 throughout READ/WRITE, and SHALL be 0 in IDLE/DONE.
REQ-008 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE.
REQ-009 A 2-bit beat counter SHALL clear on entry to READ/WRITE and increment on each cycle with resp_i=1 in READ/WRITE.
REQ-010 In READ, on each resp_i=1 cycle, burst_i SHALL be stored into line bits [64*cnt+63 : 64*cnt]; beat 0 is the least-significant.
REQ-011 In WRITE, burst_o SHALL present latched line bits [64*cnt+63 : 64*cnt] combinationally from the counter; burst_o SHALL be 0 outside WRITE.
REQ-012 When resp_i=1 with cnt=3, the FSM SHALL enter DONE on that edge; the counter wraps to 0.
REQ-013 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-014 A request still asserted during DONE SHALL NOT restart a transfer; a new request is accepted only in IDLE.
REQ-015 line_o SHALL hold the last fully assembled read line, stable from DONE until the next READ completes; partial fills SHALL NOT be visible on line_o.
REQ-016 resp_i in IDLE or DONE SHALL be ignored (no counter or data change).
REQ-017 Changes on address_i/line_i after acceptance SHALL have no effect on the in-flight transfer.
REQ-018 Minimum latency, request to resp_o, SHALL be 6 cycles: 1 accept cycle + 4 beats + 1 DONE cycle.

Reset
REQ-019 With rst=1 at a rising edge, the FSM SHALL go to IDLE, the counter to 0, and the latched address, line buffers and line_o to 0.
REQ-020 During and after reset, resp_o, read_o, write_o, address_o and burst_o SHALL be 0 in the cycle following the reset edge.
REQ-021 Reset asserted mid-transfer SHALL abort it: no resp_o is generated, and the partial line is discarded.

Verification
REQ-022 Read fill: read_i=1, address_i=0x0000_1234, burst_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i on 4 consecutive cycles.
- address_o=0x0000_1220.
- resp_o on cycle 6.
- line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
REQ-023 Write-back: write_i=1, line_i={D3,D2,D1,D0}, resp_i with 2 idle gaps.
- burst_o=D0,D1,D2,D3 in order, each held until its resp_i.
- write_o drops after beat 3.
- resp_o pulses exactly once.
REQ-024 Simultaneous read_i=write_i=1: READ is entered and write_o is never asserted.
REQ-025 Request held through DONE and dropped the cycle after: exactly one resp_o pulse, the FSM returns to IDLE, and there is no second read_o.
REQ-026 rst asserted after beat 2 of a read:
- read_o=0 next cycle.
- No resp_o.
- line_o stays 0 (or its prior value only if set before reset).
- A subsequent read completes normally.
REQ-027 Stray resp_i pulses in IDLE: counter and line_o unchanged; the next read assembles beats at correct positions.

Source files
------------

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adaptor
// Description : Bridges whole-line cache requests to a 4-beat burst memory
//               port, assembling read fills and serialising write-backs.
// Revision    : 1.0
// ============================================================================
module cacheline_adaptor #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int          CNT_W     = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [31:0] c_ADDR_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [31:0]         r_addr;
    logic [s_line-1:0]   r_rd_buf;
    logic [s_line-1:0]   r_wr_line;
    logic [s_line-1:0]   r_line_out;
    logic [s_line-1:0]   w_fill;
    logic                w_last;

    // Read buffer with the current beat merged in, so the final beat can be
    // published to line_o on the same edge it arrives.
    always_comb begin
        w_fill = r_rd_buf;
        w_fill[r_cnt*s_burst +: s_burst] = burst_i;
    end

    assign w_last = (r_cnt == CNT_W'(num_beats - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rd_buf   <= '0;
            r_wr_line  <= '0;
            r_line_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (read_i) begin
                        r_addr  <= address_i;
                        r_cnt   <= '0;
                        r_state <= READ;
                    end else if (write_i) begin
                        r_addr    <= address_i;
                        r_wr_line <= line_i;
                        r_cnt     <= '0;
                        r_state   <= WRITE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_rd_buf <= w_fill;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_line_out <= w_fill;
                            r_state    <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_line_out;
    assign resp_o    = (r_state == DONE);
    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign address_o = ((r_state == READ) || (r_state == WRITE)) ? (r_addr & c_ADDR_MASK) : '0;
    assign burst_o   = (r_state == WRITE) ? r_wr_line[r_cnt*s_burst +: s_burst] : '0;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adaptor
// Description : Directed self-checking bench for cacheline_adaptor.
// Revision    : 1.0
// ============================================================================
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int           n_cmp;
    int           n_err;
    logic [255:0] exp_line;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read transaction with beats on consecutive cycles; inputs change
    // after acceptance to show the latched address is used.
    task automatic run_read(input string tag, input logic [31:0] a, input logic [255:0] line);
        read_i    = 1'b1;
        address_i = a;
        tick();
        read_i    = 1'b0;
        address_i = ~a;
        check({tag, " read_o"}, read_o, 1'b1);
        check({tag, " write_o"}, write_o, 1'b0);
        check({tag, " address_o"}, address_o, a & 32'hFFFF_FFE0);
        for (int k = 0; k < 4; k++) begin
            resp_i  = 1'b1;
            burst_i = line[k*64 +: 64];
            tick();
            if (k < 3) begin
                check({tag, " resp_o early"}, resp_o, 1'b0);
                check({tag, " line_o partial"}, line_o, exp_line);
            end
        end
        resp_i  = 1'b0;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        exp_line = line;
        check({tag, " resp_o done"}, resp_o, 1'b1);
        check({tag, " read_o done"}, read_o, 1'b0);
        check({tag, " address_o done"}, address_o, 32'h0);
        check({tag, " line_o"}, line_o, exp_line);
        tick();
        check({tag, " resp_o idle"}, resp_o, 1'b0);
        check({tag, " line_o idle"}, line_o, exp_line);
    endtask

    logic [255:0] wline;
    logic [5:0]   wpat;
    int           beat;

    initial begin
        n_cmp = 0; n_err = 0; exp_line = '0;
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst resp_o", resp_o, 1'b0);
        check("rst read_o", read_o, 1'b0);
        check("rst write_o", write_o, 1'b0);
        check("rst address_o", address_o, 32'h0);
        check("rst burst_o", burst_o, 64'h0);
        check("rst line_o", line_o, 256'h0);
        tick();

        // Basic read fill.
        run_read("rd1", 32'h0000_1234,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write-back with two idle gaps in resp_i.
        wline = {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
                 64'hD1D1_0101_D1D1_0101, 64'h0123_4567_89AB_CDEF};
        write_i = 1'b1; address_i = 32'h8000_00FF; line_i = wline;
        tick();
        write_i = 1'b0; address_i = 32'h0; line_i = ~wline;
        check("wr write_o", write_o, 1'b1);
        check("wr read_o", read_o, 1'b0);
        check("wr address_o", address_o, 32'h8000_00E0);
        wpat = 6'b110101;
        beat = 0;
        for (int i = 0; i < 6; i++) begin
            resp_i = wpat[i];
            check($sformatf("wr burst_o c%0d", i), burst_o, wline[beat*64 +: 64]);
            check($sformatf("wr write_o c%0d", i), write_o, 1'b1);
            check($sformatf("wr resp_o c%0d", i), resp_o, 1'b0);
            tick();
            if (wpat[i]) beat++;
        end
        resp_i = 1'b0;
        check("wr write_o done", write_o, 1'b0);
        check("wr resp_o done", resp_o, 1'b1);
        check("wr burst_o done", burst_o, 64'h0);
        check("wr line_o kept", line_o, exp_line);
        tick();
        check("wr resp_o idle", resp_o, 1'b0);

        // Simultaneous read/write, held through DONE, dropped after.
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0040;
        tick();
        check("rw read_o", read_o, 1'b1);
        check("rw write_o", write_o, 1'b0);
        wline = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
                 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        for (int k = 0; k < 4; k++) begin
            resp_i  = 1'b1;
            burst_i = wline[k*64 +: 64];
            tick();
            check($sformatf("rw write_o b%0d", k), write_o, 1'b0);
        end
        resp_i = 1'b0;
        exp_line = wline;
        check("rw resp_o", resp_o, 1'b1);
        check("rw line_o", line_o, exp_line);
        tick();
        read_i = 1'b0; write_i = 1'b0;
        check("rw resp_o once", resp_o, 1'b0);
        check("rw read_o after done", read_o, 1'b0);
        check("rw write_o after done", write_o, 1'b0);
        tick();
        check("rw read_o idle", read_o, 1'b0);
        check("rw resp_o idle", resp_o, 1'b0);

        // Reset after beat 2 of a read aborts it.
        read_i = 1'b1; address_i = 32'h0000_2000;
        tick();
        read_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp_i  = 1'b1;
            burst_i = 64'hBAD0_0000_0000_0000 | 64'(k);
            tick();
        end
        resp_i = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_line = '0;
        check("abort read_o", read_o, 1'b0);
        check("abort resp_o", resp_o, 1'b0);
        check("abort line_o", line_o, exp_line);
        tick();
        check("abort resp_o later", resp_o, 1'b0);
        check("abort address_o", address_o, 32'h0);
        run_read("rd2", 32'h0000_3FFF,
                 {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                  64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A});

        // Stray resp_i pulses in IDLE.
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = 64'hFFFF_0000_FFFF_0000 + 64'(i);
            tick();
            check($sformatf("stray line_o %0d", i), line_o, exp_line);
            check($sformatf("stray read_o %0d", i), read_o, 1'b0);
            check($sformatf("stray resp_o %0d", i), resp_o, 1'b0);
        end
        resp_i = 1'b0;
        run_read("rd3", 32'hFFFF_FFFF,
                 {64'h7777_0000_0000_0003, 64'h6666_0000_0000_0002,
                  64'h5555_0000_0000_0001, 64'h4444_0000_0000_0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
